// File: rtl/miner_pkg.sv
// miner_pkg: shared widths, default geometry and the digest byte-order helper
// used by the SHA3 miner result collector.
package miner_pkg;

  localparam int STATE_W     = 1600;
  localparam int DIGEST_W    = 256;
  localparam int DEF_NONCE_W = 32;
  localparam int DEF_LATENCY = 24;

  // Byte k of the state lands in the digest with byte 0 as the MSB.
  function automatic logic [DIGEST_W-1:0] digest_of(
    input logic [STATE_W-1:0] s
  );
    logic [DIGEST_W-1:0] d;
    d = '0;
    for (int k = 0; k < DIGEST_W / 8; k++) begin
      d[DIGEST_W-1-8*k -: 8] = s[8*k +: 8];
    end
    return d;
  endfunction

endpackage

// File: rtl/miner_result_collector_nonce_fifo.sv
// nonce_fifo: circular winner FIFO with wide pointers, drop-on-full
// and a sticky overflow flag.
module nonce_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         clr_overflow,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         do_pop;
  logic         do_push;
  logic         drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = ready && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid = !empty;
  assign data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer advance; wrap comes from natural overflow of the extra bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/miner_result_collector.sv
// miner_result_collector: aligns nonces with the final round output, checks
// leading-zero difficulty, queues winners. Define MINER_HIT_COUNT_EN for hit_count.
module miner_result_collector
  import miner_pkg::*;
#(
  parameter int LATENCY    = DEF_LATENCY,
  parameter int NONCE_W    = DEF_NONCE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inj_valid,
  input  logic [NONCE_W-1:0] inj_nonce,
  input  logic [STATE_W-1:0] pipe_state,
  input  logic [7:0]         difficulty,
  output logic               res_valid,
  output logic [NONCE_W-1:0] res_nonce,
  input  logic               res_ready,
  output logic               overflow,
  input  logic               clr_overflow
`ifdef MINER_HIT_COUNT_EN
  ,
  output logic [31:0]        hit_count
`endif
);

  logic [LATENCY-1:0]  dl_valid;
  logic [NONCE_W-1:0]  dl_nonce [LATENCY];
  logic [DIGEST_W-1:0] digest;
  logic [8:0]          shamt;
  logic                zero_ok;
  logic                hit_q;
  logic [NONCE_W-1:0]  hit_nonce_q;

  // Valid bits of the delay line; bubbles shift through as zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= inj_valid;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
      end
    end
  end

  // Nonce payload of the delay line; qualified by dl_valid.
  always_ff @(posedge clk) begin
    dl_nonce[0] <= inj_nonce;
    for (int i = 1; i < LATENCY; i++) begin
      dl_nonce[i] <= dl_nonce[i-1];
    end
  end

  assign digest  = digest_of(pipe_state);
  assign shamt   = 9'd256 - {1'b0, difficulty};
  assign zero_ok = ((digest >> shamt) == '0);

  // Register the hit decision with the nonce it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q       <= 1'b0;
      hit_nonce_q <= '0;
    end else begin
      hit_q       <= dl_valid[LATENCY-1] && zero_ok;
      hit_nonce_q <= dl_nonce[LATENCY-1];
    end
  end

  nonce_fifo #(
    .W     (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (hit_q),
    .push_data    (hit_nonce_q),
    .ready        (res_ready),
    .valid        (res_valid),
    .data         (res_nonce),
    .clr_overflow (clr_overflow),
    .overflow     (overflow)
  );

`ifdef MINER_HIT_COUNT_EN
  // Saturating count of all registered hits; clear beats a same-cycle hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count <= '0;
    end else if (clr_overflow) begin
      hit_count <= '0;
    end else if (hit_q && (hit_count != 32'hFFFF_FFFF)) begin
      hit_count <= hit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miner_result_collector.sv
// tb_miner_result_collector: directed vectors plus a queue-based reference
// model compared against the DUT on every falling edge.
`timescale 1ns/1ps
module tb_miner_result_collector;

  localparam int LAT   = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inj_valid;
  logic [31:0]   inj_nonce;
  logic [1599:0] pipe_state;
  logic [7:0]    difficulty;
  logic          res_valid;
  logic [31:0]   res_nonce;
  logic          res_ready;
  logic          overflow;
  logic          clr_overflow;
`ifdef MINER_HIT_COUNT_EN
  logic [31:0]   hit_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  logic [15:0] sched [int];

  miner_result_collector #(
    .LATENCY    (LAT),
    .NONCE_W    (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inj_valid    (inj_valid),
    .inj_nonce    (inj_nonce),
    .pipe_state   (pipe_state),
    .difficulty   (difficulty),
    .res_valid    (res_valid),
    .res_nonce    (res_nonce),
    .res_ready    (res_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef MINER_HIT_COUNT_EN
    ,
    .hit_count    (hit_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mq [$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_hc = '0;
  logic [32:0] inj_hist [int];
  logic [31:0] push_at [int];
  int          m_edge = 0;

  function automatic int lead_zeros(input logic [1599:0] s);
    for (int j = 0; j < 256; j++) begin
      if (s[8*(j/8) + 7 - (j%8)]) return j;
    end
    return 256;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      inj_hist.delete();
      push_at.delete();
      m_ovf = 1'b0;
      m_hc  = '0;
    end else begin
      logic drop;
      logic pushed;
      drop   = 1'b0;
      pushed = 1'b0;
      inj_hist[m_edge] = {inj_valid, inj_nonce};
      if (inj_hist.exists(m_edge - LAT)) begin
        if (inj_hist[m_edge-LAT][32] &&
            lead_zeros(pipe_state) >= int'(difficulty))
          push_at[m_edge+1] = inj_hist[m_edge-LAT][31:0];
        inj_hist.delete(m_edge - LAT);
      end
      if (res_ready && mq.size() > 0) void'(mq.pop_front());
      if (push_at.exists(m_edge)) begin
        pushed = 1'b1;
        if (mq.size() < DEPTH) mq.push_back(push_at[m_edge]);
        else drop = 1'b1;
        push_at.delete(m_edge);
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      if (clr_overflow) m_hc = '0;
      else if (pushed && m_hc != 32'hFFFF_FFFF) m_hc = m_hc + 1;
    end
    m_edge++;
  end

  // Compare process: every falling edge once enabled.
  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (res_valid !== (mq.size() > 0)) begin
        miscompares++;
        $display("FAIL model_valid cyc=%0d got=%0b exp=%0b",
                 cyc, res_valid, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        vectors++;
        if (res_nonce !== mq[0]) begin
          miscompares++;
          $display("FAIL model_nonce cyc=%0d got=%h exp=%h",
                   cyc, res_nonce, mq[0]);
        end
      end
      vectors++;
      if (overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL model_overflow cyc=%0d got=%0b exp=%0b",
                 cyc, overflow, m_ovf);
      end
`ifdef MINER_HIT_COUNT_EN
      vectors++;
      if (hit_count !== m_hc) begin
        miscompares++;
        $display("FAIL model_hit_count cyc=%0d got=%0d exp=%0d",
                 cyc, hit_count, m_hc);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int w = 0; w < 50; w++) pipe_state[32*w +: 32] = $urandom;
    if (sched.exists(cyc)) begin
      pipe_state[7:0]  = sched[cyc][7:0];
      pipe_state[15:8] = sched[cyc][15:8];
      sched.delete(cyc);
    end
  endtask

  task automatic send(input logic [31:0] n, input logic v,
                      input logic [7:0] b0, input logic [7:0] b1);
    inj_valid = v;
    inj_nonce = n;
    sched[cyc + LAT] = {b1, b0};
    tick();
    inj_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pop_expect(input string name, input logic [31:0] exp);
    check({name, "_valid"}, 64'(res_valid), 64'd1);
    check({name, "_nonce"}, 64'(res_nonce), 64'(exp));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k;
    reset        = 1'b1;
    inj_valid    = 1'b0;
    inj_nonce    = '0;
    pipe_state   = '0;
    difficulty   = 8'd0;
    res_ready    = 1'b0;
    clr_overflow = 1'b0;
    idle(3);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_res_nonce", 64'(res_nonce), 64'd0);
    check("reset_overflow",  64'(overflow),  64'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // Alignment and order, difficulty 0.
    for (int i = 0; i < 4; i++) send(32'h10 + i, 1'b1, 8'hFF, 8'hFF);
    k = 4;
    while (!res_valid && k < 60) begin
      tick();
      k++;
    end
    check("first_valid_latency", 64'(k), 64'd26);
    idle(4);
    for (int i = 0; i < 4; i++) pop_expect("align", 32'h10 + i);
    check("align_empty", 64'(res_valid), 64'd0);

    // Difficulty boundaries.
    difficulty = 8'd8;
    send(32'hA0, 1'b1, 8'h00, 8'h80);
    send(32'hA1, 1'b1, 8'h01, 8'h80);
    idle(30);
    pop_expect("diff8_hit", 32'hA0);
    check("diff8_nohit", 64'(res_valid), 64'd0);
    difficulty = 8'd9;
    send(32'hB0, 1'b1, 8'h00, 8'h40);
    send(32'hB1, 1'b1, 8'h00, 8'h80);
    idle(30);
    pop_expect("diff9_hit", 32'hB0);
    check("diff9_nohit", 64'(res_valid), 64'd0);

    // Bubbles.
    difficulty = 8'd0;
    send(32'h21, 1'b1, 8'h00, 8'h00);
    send(32'h22, 1'b0, 8'h00, 8'h00);
    send(32'h23, 1'b1, 8'h00, 8'h00);
    idle(30);
    pop_expect("bubble0", 32'h21);
    pop_expect("bubble1", 32'h23);
    check("bubble_empty", 64'(res_valid), 64'd0);

    // Full and overflow.
    for (int i = 0; i < 5; i++) send(32'h31 + i, 1'b1, 8'h00, 8'h00);
    idle(30);
    check("ovf_set", 64'(overflow), 64'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_expect("ovf_drain", 32'h31 + i);
    check("ovf_empty", 64'(res_valid), 64'd0);

    // Push and pop together while full.
    for (int i = 0; i < 5; i++) send(32'h41 + i, 1'b1, 8'h00, 8'h00);
    idle(24);
    check("pp_full_head", 64'(res_nonce), 64'h41);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("pp_no_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_expect("pp_drain", 32'h42 + i);
    check("pp_empty", 64'(res_valid), 64'd0);

    // Async reset mid-stream.
    for (int i = 0; i < 3; i++) send(32'h51 + i, 1'b1, 8'h00, 8'h00);
    idle(27);
    send(32'h54, 1'b1, 8'h00, 8'h00);
    send(32'h55, 1'b1, 8'h00, 8'h00);
    idle(3);
    check("pre_reset_valid", 64'(res_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", 64'(res_valid), 64'd0);
    tick();
    reset = 1'b0;
    idle(40);
    check("post_reset_valid", 64'(res_valid), 64'd0);
    check("post_reset_ovf", 64'(overflow), 64'd0);
`ifdef MINER_HIT_COUNT_EN
    check("post_reset_hit_count", 64'(hit_count), 64'd0);
`endif

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/miner_result_collector.md
Name: miner_result_collector

Overview:
- Sits at the far end of the SHA3-256 round pipeline and consumes the 1600-bit state leaving the final round stage.
- Tracks which nonce each output state belongs to using a nonce delay line matched to pipeline latency.
- Checks the 256-bit digest against a leading-zero difficulty and queues winning nonces in a small FIFO.
- Software or the bus bridge drains the FIFO through a valid/ready handshake.

Parameters:
- LATENCY, 24, pipeline depth in clocks from nonce injection to final-round output; sets delay-line length.
- NONCE_W, 32, nonce width in bits.
- FIFO_DEPTH, 4, winning-nonce FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inj_valid  in  1  a nonce was injected into round 0 this cycle.
- inj_nonce  in  NONCE_W  nonce injected this cycle.
- pipe_state  in  1600  registered output of the final round stage.
- difficulty  in  8  required count of leading zero digest bits, 0..255; quasi-static.
- res_valid  out  1  FIFO head holds a winning nonce.
- res_nonce  out  NONCE_W  FIFO head nonce.
- res_ready  in  1  consumer accepts the head.
- overflow  out  1  sticky: a winner was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset: delay line valid bits 0, FIFO empty, res_valid 0, res_nonce 0, overflow 0. Reset mid-operation discards all in-flight nonces and FIFO contents.
- Delay line: a LATENCY-stage shift register of {valid, nonce}, loaded from inj_valid/inj_nonce.
  - Stage LATENCY-1 aligns with pipe_state in the same cycle.
  - Invalid slots shift through as bubbles.
- Digest: bytes 0..31 of pipe_state, where byte k = pipe_state[8k+7:8k].
  - Form D (256 bits) with byte 0 as the most significant byte.
  - hit = aligned valid AND (D >> (256 - difficulty)) == 0.
  - difficulty 0 means every valid output hits.
- Hit detection is registered (1 cycle). A hit nonce is written into the FIFO on the following edge.
  - First res_valid appears LATENCY+2 clocks after injection.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - Full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
  - Wrap-around is by natural pointer overflow.
- Handshake: a pop occurs when res_valid && res_ready.
  - res_nonce is stable while res_valid is high and not popped.
  - res_nonce is don't-care when res_valid = 0.
- Simultaneous push and pop:
  - When full, both succeed and nothing is dropped (pop frees the slot).
  - When empty, the push succeeds and the pop does nothing (res_valid was 0).
- Push while full without a pop: the nonce is discarded and overflow is set.
- clr_overflow and a new overflow event in the same cycle: overflow stays 1 (set wins).
- Changing difficulty in flight affects only hits evaluated after the change; there is no retro-check.

Optional Feature:
- Macro: MINER_HIT_COUNT_EN.
- When defined:
  - Adds output hit_count [31:0], reset to 0.
  - hit_count increments on every registered hit, including dropped ones, and saturates at 0xFFFFFFFF.
  - clr_overflow also clears hit_count; if a hit coincides with the clear, the clear wins and the count becomes 0.
- When undefined: the port and counter are absent and there is no other behavioural change.

Decomposition:
- Shared package miner_pkg holds:
  - STATE_W = 1600, DIGEST_W = 256, NONCE_W default, LATENCY default.
  - A digest byte-order helper function.
- Natural sub-module: nonce_fifo (parameterised circular FIFO with full, empty and drop/overflow).
- The delay line and hit compare stay in the top level.

Test Plan:
- Reset alignment: inject nonces 0x10..0x13 on consecutive cycles with difficulty 0 and pipe_state driven arbitrarily.
  - res_valid first rises 26 clocks after the first injection.
  - Popping with res_ready = 1 yields 0x10, 0x11, 0x12, 0x13 in order.
- Difficulty boundary: difficulty 8 with byte 0 = 0x00, byte 1 = 0x80 -> hit.
  - Byte 0 = 0x01 -> no hit.
  - Difficulty 9 with byte 0 = 0x00, byte 1 = 0x40 -> hit; byte 1 = 0x80 -> no hit.
- Bubbles: inj_valid pattern 1,0,1 with every state hitting -> exactly 2 FIFO entries, nonces of the valid slots only.
- Full/overflow: res_ready = 0 with 5 hits and FIFO_DEPTH 4.
  - FIFO holds the first 4 nonces and overflow = 1.
  - clr_overflow -> overflow = 0; drained order is unchanged.
- Simultaneous push/pop at full: a hit arrives in the same cycle res_ready pops -> no drop, overflow stays 0, count stays 4.
- Async reset mid-stream: assert reset between clock edges with 3 entries queued and nonces in flight.
  - res_valid drops immediately and stays 0 after release.
  - Nonces injected before reset never appear.
  - With MINER_HIT_COUNT_EN, hit_count = 0.
